prv664_wb_arbiter: RTL



---
 rtl/prv664_wb_arbiter_if.sv | 34 +++
 rtl/prv664_wb_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/prv664_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : prv664_wb_arbiter_if
// Description : Source-channel and ROB-writeback bundle for prv664_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface prv664_wb_arbiter_if #(
    parameter int NSRC      = 8,
    parameter int NPORT     = 2,
    parameter int ITAG_W    = 8,
    parameter int PAYLOAD_W = 200
);
    logic [NSRC-1:0]            src_valid_i;
    logic [NSRC-1:0]            src_ready_o;
    logic [NSRC*ITAG_W-1:0]     src_itag_i;
    logic [NSRC*PAYLOAD_W-1:0]  src_payload_i;
    logic [NPORT-1:0]           wb_valid_o;
    logic [NPORT-1:0]           wb_ready_i;
    logic [NPORT*ITAG_W-1:0]    wb_itag_o;
    logic [NPORT*PAYLOAD_W-1:0] wb_payload_o;

    // Arbiter side
    modport slave (
        input  src_valid_i, src_itag_i, src_payload_i, wb_ready_i,
        output src_ready_o, wb_valid_o, wb_itag_o, wb_payload_o
    );

    // Execution-unit / ROB side
    modport master (
        output src_valid_i, src_itag_i, src_payload_i, wb_ready_i,
        input  src_ready_o, wb_valid_o, wb_itag_o, wb_payload_o
    );
endinterface
`default_nettype wire

// File: rtl/prv664_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : prv664_wb_arbiter
// Description : Routes NSRC writeback channels to NPORT registered ROB ports,
//               round-robin per port. Optional flush_i via PRV664_WB_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module prv664_wb_arbiter #(
    parameter int NSRC      = 8,
    parameter int NPORT     = 2,
    parameter int ITAG_W    = 8,
    parameter int PAYLOAD_W = 200
) (
    input  wire logic clk_i,
    input  wire logic srst_n,
`ifdef PRV664_WB_FLUSH_EN
    input  wire logic flush_i,
`endif
    prv664_wb_arbiter_if.slave io_bus
);
    localparam int c_SRC_W  = $clog2(NSRC);
    localparam int c_BANK_W = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam logic [c_SRC_W:0] c_NSRC_EXT = (c_SRC_W+1)'(NSRC);

    logic [c_BANK_W-1:0]                 w_bank [NSRC];
    logic [NPORT-1:0][NSRC-1:0]          w_req;
    logic [NPORT-1:0]                    w_gnt_vld;
    logic [NPORT-1:0][c_SRC_W-1:0]       w_gnt_idx;
    logic [NPORT-1:0][c_SRC_W-1:0]       w_rr_nxt;
    logic [NPORT-1:0]                    w_load_ok;
    logic [NPORT-1:0]                    w_acc;
    logic [NSRC-1:0]                     w_src_rdy;
    logic [NPORT-1:0][ITAG_W-1:0]        w_sel_itag;
    logic [NPORT-1:0][PAYLOAD_W-1:0]     w_sel_pl;
    logic [c_SRC_W:0]                    w_sum;
    logic                                w_flush;
    logic                                w_live;

    logic [NPORT-1:0]                    r_valid;
    logic [NPORT-1:0][ITAG_W-1:0]        r_itag;
    logic [NPORT-1:0][PAYLOAD_W-1:0]     r_pl;
    logic [NPORT-1:0][c_SRC_W-1:0]       r_rr;

`ifdef PRV664_WB_FLUSH_EN
    assign w_flush = flush_i;
`else
    assign w_flush = 1'b0;
`endif
    // Nothing is accepted while in reset or in a flush cycle
    assign w_live = srst_n & ~w_flush;

    generate
        if (NPORT > 1) begin : g_bank_sel
            for (genvar i = 0; i < NSRC; i++) begin : g_src
                assign w_bank[i] = io_bus.src_itag_i[i*ITAG_W + ITAG_W - 1 -: c_BANK_W];
            end
        end else begin : g_bank_zero
            for (genvar i = 0; i < NSRC; i++) begin : g_src
                assign w_bank[i] = '0;
            end
        end
    endgenerate

    always_comb begin
        w_req = '0;
        for (int p = 0; p < NPORT; p++) begin
            for (int i = 0; i < NSRC; i++) begin
                w_req[p][i] = io_bus.src_valid_i[i] & (w_bank[i] == c_BANK_W'(p));
            end
        end
    end

    // Scan from the far end toward rr so the closest requester wins last
    always_comb begin
        w_sum     = '0;
        w_gnt_vld = '0;
        w_gnt_idx = '0;
        for (int p = 0; p < NPORT; p++) begin
            for (int k = NSRC - 1; k >= 0; k--) begin
                w_sum = {1'b0, r_rr[p]} + (c_SRC_W+1)'(k);
                if (w_sum >= c_NSRC_EXT) begin
                    w_sum = w_sum - c_NSRC_EXT;
                end
                if (w_req[p][w_sum[c_SRC_W-1:0]]) begin
                    w_gnt_vld[p] = 1'b1;
                    w_gnt_idx[p] = w_sum[c_SRC_W-1:0];
                end
            end
        end
    end

    always_comb begin
        w_load_ok  = '0;
        w_acc      = '0;
        w_rr_nxt   = '0;
        w_sel_itag = '0;
        w_sel_pl   = '0;
        for (int p = 0; p < NPORT; p++) begin
            w_load_ok[p] = ~r_valid[p] | io_bus.wb_ready_i[p];
            w_acc[p]     = w_gnt_vld[p] & w_load_ok[p] & w_live;
            w_rr_nxt[p]  = (w_gnt_idx[p] == c_SRC_W'(NSRC - 1)) ? '0 : w_gnt_idx[p] + 1'b1;
            for (int i = 0; i < NSRC; i++) begin
                if (w_gnt_idx[p] == c_SRC_W'(i)) begin
                    w_sel_itag[p] = io_bus.src_itag_i[i*ITAG_W +: ITAG_W];
                    w_sel_pl[p]   = io_bus.src_payload_i[i*PAYLOAD_W +: PAYLOAD_W];
                end
            end
        end
    end

    always_comb begin
        w_src_rdy = '0;
        for (int i = 0; i < NSRC; i++) begin
            for (int p = 0; p < NPORT; p++) begin
                if ((w_bank[i] == c_BANK_W'(p)) && (w_gnt_idx[p] == c_SRC_W'(i)) && w_acc[p]) begin
                    w_src_rdy[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n) begin
            r_valid <= '0;
            r_itag  <= '0;
            r_pl    <= '0;
            r_rr    <= '0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                if (w_acc[p]) begin
                    r_valid[p] <= 1'b1;
                    r_itag[p]  <= w_sel_itag[p];
                    r_pl[p]    <= w_sel_pl[p];
                    r_rr[p]    <= w_rr_nxt[p];
                end else if (w_flush) begin
                    r_valid[p] <= 1'b0;
                end else begin
                    r_valid[p] <= r_valid[p] & ~io_bus.wb_ready_i[p];
                end
            end
        end
    end

    assign io_bus.src_ready_o  = w_src_rdy;
    assign io_bus.wb_valid_o   = r_valid;
    assign io_bus.wb_itag_o    = r_itag;
    assign io_bus.wb_payload_o = r_pl;

`ifdef SIMULATION
    // A waiting source must hold its packet until it is taken
    generate
        for (genvar i = 0; i < NSRC; i++) begin : g_src_stable
            a_src_stable : assert property (@(posedge clk_i) disable iff (!srst_n)
                (io_bus.src_valid_i[i] && !io_bus.src_ready_o[i]) |=>
                (io_bus.src_valid_i[i]
                 && $stable(io_bus.src_itag_i[i*ITAG_W +: ITAG_W])
                 && $stable(io_bus.src_payload_i[i*PAYLOAD_W +: PAYLOAD_W])));
        end
    endgenerate
`endif
endmodule
`default_nettype wire
